// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock
// over a shared N+1-bit adder, with valid/ready handshakes on both sides.
module booth_mul_seq #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   ain,
  input  logic [N-1:0]   bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   prod,
  output logic [2*N-1:0] prod_full,
  output logic           overflow,
  output logic           busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [N:0]       m_q;
  logic [N:0]       a_q;
  logic [N-1:0]     q_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     prod_q;
  logic [2*N-1:0]   full_q;
  logic             ovf_q;

  logic [N:0]       sum;
  logic [N:0]       a_d;
  logic [N-1:0]     q_d;
  logic [2*N-1:0]   full_d;
  logic             ovf_d;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of {A,Q,q_m1}.
  always_comb begin
    sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_d    = {sum[N], sum[N:1]};
    q_d    = {sum[0], q_q[N-1:1]};
    full_d = {a_d[N-1:0], q_d};
    ovf_d  = !((&full_d[2*N-1:N-1]) || !(|full_d[2*N-1:N-1]));
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath is reset too, so an abort leaves no stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            m_q     <= {ain[N-1], ain};
            a_q     <= '0;
            q_q     <= bin;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            full_q  <= full_d;
            prod_q  <= q_d;
            ovf_q   <= ovf_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign prod      = prod_q;
  assign prod_full = full_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: table of signed 6-bit products plus backpressure,
// handshake-overlap and asynchronous-abort sequences, checked via a result queue.
module tb_booth_mul_seq;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   ain = '0;
  logic [N-1:0]   bin = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   prod;
  logic [2*N-1:0] prod_full;
  logic           overflow;
  logic           busy;

  booth_mul_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .prod_full (prod_full),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] full;
    logic           ovf;
  } vec_t;

  typedef struct {
    logic [2*N-1:0] full;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at a negedge; the following posedge accepts them.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] full, input logic ovf);
    exp_t e;
    @(negedge clk);
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1;
    ain = a;
    bin = b;
    e.full = full;
    e.ovf  = ovf;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    ain = ~a;
    bin = ~b;
    check("in_ready after accept", in_ready, 0);
    check("busy after accept", busy, 1);
  endtask

  // Called on the negedge right after the accept edge.
  task automatic wait_result(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, 6);
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, " prod_full"}, prod_full, e.full);
      check({name, " prod"}, prod, e.full[N-1:0]);
      check({name, " overflow"}, overflow, e.ovf);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after consume", out_valid, 0);
    check("in_ready after consume", in_ready, 1);
  endtask

  vec_t vecs[11];
  logic [2*N-1:0] held_full;
  logic           held_ovf;

  initial begin
    vecs[0]  = '{6'd3,  6'd5,  12'h00F, 1'b0};
    vecs[1]  = '{6'h3C, 6'd7,  12'hFE4, 1'b0};
    vecs[2]  = '{6'h20, 6'h20, 12'h400, 1'b1};
    vecs[3]  = '{6'd8,  6'd4,  12'h020, 1'b1};
    vecs[4]  = '{6'd0,  6'h20, 12'h000, 1'b0};
    vecs[5]  = '{6'h3F, 6'h20, 12'h020, 1'b1};
    vecs[6]  = '{6'd31, 6'd31, 12'h3C1, 1'b1};
    vecs[7]  = '{6'h20, 6'd31, 12'hC20, 1'b1};
    vecs[8]  = '{6'h3D, 6'h3D, 12'h009, 1'b0};
    vecs[9]  = '{6'h20, 6'd1,  12'hFE0, 1'b0};
    vecs[10] = '{6'd5,  6'h3A, 12'hFE2, 1'b0};

    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset prod_full", prod_full, 0);
    check("reset prod", prod, 0);
    check("reset overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].full, vecs[i].ovf);
      wait_result($sformatf("vec%0d", i));
      consume();
    end

    // Backpressure: result held while in_valid pulses, then overlap with handshake.
    issue(6'd7, 6'h3E, 12'hFF2, 1'b0);
    wait_result("bp");
    held_full = 12'hFF2;
    held_ovf  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      ain = 6'd2;
      bin = 6'd3;
      @(negedge clk);
      check("bp out_valid held", out_valid, 1);
      check("bp busy held", busy, 1);
      check("bp in_ready low", in_ready, 0);
      check("bp prod_full stable", prod_full, held_full);
      check("bp overflow stable", overflow, held_ovf);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap out_valid", out_valid, 0);
    check("overlap in_ready (no accept)", in_ready, 1);
    sb.push_back('{12'h006, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap accepted next edge", in_ready, 0);
    wait_result("overlap");
    consume();

    // Asynchronous abort after step 3 of 3*5.
    issue(6'd3, 6'd5, 12'h00F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort busy before reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 1);
    check("abort prod_full", prod_full, 0);
    check("abort overflow", overflow, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'h3B, 6'd6, 12'hFE2, 1'b0);
    wait_result("after abort");
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
